// File: rtl/eth_miim_arb_if.sv
// Bus bundle for eth_miim_arb: requester A/B handshakes, poller status and the MIIM command side.
interface eth_miim_arb_if;
    logic        ReqA;
    logic        ReqB;
    logic        WrA;
    logic        WrB;
    logic [4:0]  FiadA;
    logic [4:0]  FiadB;
    logic [4:0]  RgadA;
    logic [4:0]  RgadB;
    logic [15:0] WdatA;
    logic [15:0] WdatB;
    logic        AckA;
    logic        AckB;
    logic        ErrA;
    logic        ErrB;
    logic [15:0] Rdat;
    logic [4:0]  PollFiad;
    logic        LinkUp;
    logic        PollDone;
    logic        WCtrlData;
    logic        RStat;
    logic [4:0]  Fiad;
    logic [4:0]  Rgad;
    logic [15:0] CtrlData;
    logic        MiimBusy;
    logic        MiimWStart;
    logic        MiimRStart;
    logic        MiimUpd;
    logic [15:0] MiimPrsd;

    // Arbiter side
    modport slave (
        input  ReqA, ReqB, WrA, WrB, FiadA, FiadB, RgadA, RgadB, WdatA, WdatB, PollFiad,
        input  MiimBusy, MiimWStart, MiimRStart, MiimUpd, MiimPrsd,
        output AckA, AckB, ErrA, ErrB, Rdat, LinkUp, PollDone,
        output WCtrlData, RStat, Fiad, Rgad, CtrlData
    );

    // Requesters plus MIIM model side
    modport master (
        output ReqA, ReqB, WrA, WrB, FiadA, FiadB, RgadA, RgadB, WdatA, WdatB, PollFiad,
        output MiimBusy, MiimWStart, MiimRStart, MiimUpd, MiimPrsd,
        input  AckA, AckB, ErrA, ErrB, Rdat, LinkUp, PollDone,
        input  WCtrlData, RStat, Fiad, Rgad, CtrlData
    );
endinterface

// File: rtl/eth_miim_arb.sv
// eth_miim_arb: shares one MIIM management master between requesters A/B and a
// periodic BMSR link poller, with round-robin between A and B and a transaction timeout.
//
//  state   | meaning
//  IDLE    | arbitrate; latch winner's command
//  ISSUE   | WCtrlData/RStat held until the MIIM reports start
//  WAIT    | command dropped, waiting for MiimBusy to fall; capture Prsd on update
//  DONE    | one cycle: Ack/PollDone pulse, Rdat valid
module eth_miim_arb #(
    parameter logic [31:0] POLL_CYCLES = 32'd1000000,
    parameter logic [15:0] TIMEOUT     = 16'd8192
) (
    input  logic          Clk,
    input  logic          Reset_n,
    eth_miim_arb_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_A, OWN_B, OWN_POLL} owner_t;

    localparam logic [4:0] BMSR_ADDR = 5'd1;

    state_t      r_state;
    state_t      w_state_nxt;
    owner_t      r_owner;
    logic        r_rr;          // tie-break: 0 favours A, 1 favours B
    logic        r_wr;
    logic        r_err;
    logic        r_poll_pend;
    logic        r_linkup;
    logic [4:0]  r_fiad;
    logic [4:0]  r_rgad;
    logic [15:0] r_wdat;
    logic [15:0] r_prsd;
    logic [15:0] r_rdat;
    logic [15:0] r_tcnt;
    logic [31:0] r_pcnt;

    logic        w_grant_a;
    logic        w_grant_b;
    logic        w_grant_poll;
    logic        w_grant;
    logic        w_busy_phase;
    logic        w_timeout;
    logic        w_start_seen;
    logic        w_enter_done;
    logic        w_done;
    logic        w_poll_tick;
    logic [15:0] w_prsd_nxt;

    assign w_grant      = w_grant_a | w_grant_b | w_grant_poll;
    assign w_busy_phase = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign w_timeout    = w_busy_phase && (r_tcnt == TIMEOUT - 16'd1);
    assign w_start_seen = r_wr ? bus.MiimWStart : bus.MiimRStart;
    assign w_enter_done = w_busy_phase && (w_state_nxt == S_DONE);
    assign w_done       = (r_state == S_DONE);
    assign w_poll_tick  = (POLL_CYCLES != 32'd0) && (r_pcnt == POLL_CYCLES - 32'd1);
    // An update arriving on the same cycle Busy falls must still reach Rdat.
    assign w_prsd_nxt   = ((r_state == S_WAIT) && bus.MiimUpd && !r_wr) ? bus.MiimPrsd : r_prsd;

    // Arbitration in IDLE and next-state selection
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_a    = 1'b0;
        w_grant_b    = 1'b0;
        w_grant_poll = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ReqA && (!bus.ReqB || !r_rr)) begin
                    w_grant_a = 1'b1;
                end else if (bus.ReqB) begin
                    w_grant_b = 1'b1;
                end else if (r_poll_pend) begin
                    w_grant_poll = 1'b1;
                end
                if (w_grant_a || w_grant_b || w_grant_poll) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_timeout) begin
                    w_state_nxt = S_DONE;
                end else if (w_start_seen) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_timeout || !bus.MiimBusy) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command latch at grant, timeout counter, read capture and completion results
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_owner  <= OWN_A;
            r_wr     <= 1'b0;
            r_fiad   <= 5'd0;
            r_rgad   <= 5'd0;
            r_wdat   <= 16'd0;
            r_tcnt   <= 16'd0;
            r_prsd   <= 16'd0;
            r_rdat   <= 16'd0;
            r_err    <= 1'b0;
            r_linkup <= 1'b0;
        end else begin
            if (w_grant_a) begin
                r_owner <= OWN_A;
                r_wr    <= bus.WrA;
                r_fiad  <= bus.FiadA;
                r_rgad  <= bus.RgadA;
                r_wdat  <= bus.WdatA;
            end else if (w_grant_b) begin
                r_owner <= OWN_B;
                r_wr    <= bus.WrB;
                r_fiad  <= bus.FiadB;
                r_rgad  <= bus.RgadB;
                r_wdat  <= bus.WdatB;
            end else if (w_grant_poll) begin
                r_owner <= OWN_POLL;
                r_wr    <= 1'b0;
                r_fiad  <= bus.PollFiad;
                r_rgad  <= BMSR_ADDR;
                r_wdat  <= 16'd0;
            end

            if (w_grant) begin
                r_tcnt <= 16'd0;
                r_prsd <= 16'd0;
            end else begin
                if (w_busy_phase) begin
                    r_tcnt <= r_tcnt + 16'd1;
                end
                r_prsd <= w_prsd_nxt;
            end

            if (w_enter_done) begin
                r_err  <= w_timeout;
                r_rdat <= (w_timeout || r_wr) ? 16'd0 : w_prsd_nxt;
                if ((r_owner == OWN_POLL) && !w_timeout) begin
                    r_linkup <= w_prsd_nxt[2];
                end
            end
        end
    end

    // Round-robin pointer hands priority to the requester that was not just served
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rr <= 1'b0;
        end else if (w_done) begin
            if (r_owner == OWN_A) begin
                r_rr <= 1'b1;
            end else if (r_owner == OWN_B) begin
                r_rr <= 1'b0;
            end
        end
    end

    // Free-running poll timer; a due poll is a single flag, so missed periods never stack
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pcnt      <= 32'd0;
            r_poll_pend <= 1'b0;
        end else begin
            if (w_poll_tick || (POLL_CYCLES == 32'd0)) begin
                r_pcnt <= 32'd0;
            end else begin
                r_pcnt <= r_pcnt + 32'd1;
            end
            if (w_poll_tick) begin
                r_poll_pend <= 1'b1;
            end else if (w_grant_poll) begin
                r_poll_pend <= 1'b0;
            end
        end
    end

    assign bus.AckA      = w_done && (r_owner == OWN_A);
    assign bus.AckB      = w_done && (r_owner == OWN_B);
    assign bus.ErrA      = w_done && (r_owner == OWN_A) && r_err;
    assign bus.ErrB      = w_done && (r_owner == OWN_B) && r_err;
    assign bus.PollDone  = w_done && (r_owner == OWN_POLL);
    assign bus.Rdat      = r_rdat;
    assign bus.LinkUp    = r_linkup;
    assign bus.WCtrlData = (r_state == S_ISSUE) && r_wr;
    assign bus.RStat     = (r_state == S_ISSUE) && !r_wr;
    assign bus.Fiad      = r_fiad;
    assign bus.Rgad      = r_rgad;
    assign bus.CtrlData  = r_wdat;
endmodule

// File: tb/tb_eth_miim_arb.sv
// Directed bench for eth_miim_arb with a small MIIM model driven on the falling clock edge.
module tb_eth_miim_arb;
    localparam logic [4:0] POLL_FIAD = 5'd7;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic        bfm_no_start = 1'b0;
    logic [15:0] poll_data = 16'h0004;

    eth_miim_arb_if bus();

    eth_miim_arb #(.POLL_CYCLES(32'd100), .TIMEOUT(16'd64)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // MIIM model: start pulse two cycles after the command, Busy for 8 cycles, Prsd update for reads
    function automatic logic [15:0] prsd_of(input logic [4:0] f);
        case (f)
            5'd2:      return 16'h1234;
            5'd3:      return 16'hABCD;
            POLL_FIAD: return poll_data;
            default:   return 16'h5A5A;
        endcase
    endfunction

    int          b_dly;
    int          b_cnt;
    logic        b_rd;
    logic [15:0] b_data;

    always @(negedge Clk) begin
        if (!Reset_n) begin
            bus.MiimBusy   = 1'b0;
            bus.MiimWStart = 1'b0;
            bus.MiimRStart = 1'b0;
            bus.MiimUpd    = 1'b0;
            bus.MiimPrsd   = 16'd0;
            b_dly  = 0;
            b_cnt  = 0;
            b_rd   = 1'b0;
            b_data = 16'd0;
        end else begin
            bus.MiimWStart = 1'b0;
            bus.MiimRStart = 1'b0;
            bus.MiimUpd    = 1'b0;
            if (bus.MiimBusy) begin
                b_cnt = b_cnt - 1;
                if (b_cnt == 2 && b_rd) begin
                    bus.MiimPrsd = b_data;
                    bus.MiimUpd  = 1'b1;
                end
                if (b_cnt == 0) bus.MiimBusy = 1'b0;
            end else if (bus.WCtrlData || (bus.RStat && !bfm_no_start)) begin
                b_dly = b_dly + 1;
                if (b_dly == 2) begin
                    b_dly = 0;
                    if (bus.WCtrlData) bus.MiimWStart = 1'b1;
                    else               bus.MiimRStart = 1'b1;
                    bus.MiimBusy = 1'b1;
                    b_cnt  = 8;
                    b_rd   = bus.RStat;
                    b_data = prsd_of(bus.Fiad);
                end
            end else begin
                b_dly = 0;
            end
        end
    end

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for the next Ack pulse, records it and drops the acknowledged request.
    task automatic wait_ack(output logic [1:0] ab, output logic [15:0] rd, output logic [1:0] er);
        int cyc = 0;
        while (!(bus.AckA || bus.AckB) && cyc < 300) begin
            tick();
            cyc++;
        end
        ab = {bus.AckA, bus.AckB};
        rd = bus.Rdat;
        er = {bus.ErrA, bus.ErrB};
        if (bus.AckA) bus.ReqA = 1'b0;
        if (bus.AckB) bus.ReqB = 1'b0;
        tick();
    endtask

    // Cycles from now to the next PollDone (at least one).
    task automatic wait_poll(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.PollDone && cyc < 400);
    endtask

    logic [1:0]  ab;
    logic [1:0]  er;
    logic [15:0] rd;
    int          cyc;
    int          lat;
    int          acks;
    logic        held;
    logic        pd_seen;

    initial begin
        bus.ReqA = 1'b0;  bus.ReqB = 1'b0;
        bus.WrA = 1'b0;   bus.WrB = 1'b0;
        bus.FiadA = 5'd0; bus.FiadB = 5'd0;
        bus.RgadA = 5'd0; bus.RgadB = 5'd0;
        bus.WdatA = 16'd0; bus.WdatB = 16'd0;
        bus.PollFiad = POLL_FIAD;
        Reset_n = 1'b0;
        repeat (3) tick();

        check("reset_flags", 32'({bus.AckA, bus.AckB, bus.ErrA, bus.ErrB, bus.LinkUp,
                                  bus.PollDone, bus.WCtrlData, bus.RStat}), 32'd0);
        check("reset_rdat", 32'(bus.Rdat), 32'd0);
        check("reset_cmd", 32'({bus.Fiad, bus.Rgad, bus.CtrlData}), 32'd0);
        Reset_n = 1'b1;

        // 1: single write from A
        bus.WrA = 1'b1; bus.FiadA = 5'd1; bus.RgadA = 5'd0; bus.WdatA = 16'h8000;
        bus.ReqA = 1'b1;
        tick();
        lat = 1;
        check("t1_wctrl_up", 32'(bus.WCtrlData), 32'd1);
        check("t1_cmd", 32'({bus.Fiad, bus.Rgad, bus.CtrlData}), 32'({5'd1, 5'd0, 16'h8000}));
        held = 1'b1;
        cyc = 0;
        while (!bus.MiimWStart && cyc < 20) begin
            if (!bus.WCtrlData) held = 1'b0;
            tick();
            cyc++;
            lat++;
        end
        check("t1_wctrl_held", 32'({held, bus.MiimWStart}), 32'b11);
        tick();
        lat++;
        check("t1_wctrl_drop", 32'(bus.WCtrlData), 32'd0);
        cyc = 0;
        while (!bus.AckA && cyc < 100) begin
            tick();
            cyc++;
            lat++;
        end
        check("t1_ack", 32'({bus.AckA, bus.ErrA, bus.MiimBusy}), 32'b100);
        check("t1_rdat_write", 32'(bus.Rdat), 32'd0);
        check("t1_ack_latency_ge4", 32'(lat >= 4), 32'd1);
        bus.ReqA = 1'b0;
        acks = 0;
        repeat (20) begin
            tick();
            if (bus.AckA) acks++;
        end
        check("t1_single_ack", 32'(acks), 32'd0);

        // 2: round robin with fresh pointer
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        bus.WrA = 1'b0; bus.FiadA = 5'd2; bus.RgadA = 5'd3;
        bus.WrB = 1'b0; bus.FiadB = 5'd3; bus.RgadB = 5'd4;
        bus.ReqA = 1'b1; bus.ReqB = 1'b1;
        wait_ack(ab, rd, er);
        check("t2_pair1_first_a", 32'({ab, er}), 32'b1000);
        check("t2_pair1_rdat_a", 32'(rd), 32'h1234);
        wait_ack(ab, rd, er);
        check("t2_pair1_second_b", 32'({ab, er}), 32'b0100);
        check("t2_pair1_rdat_b", 32'(rd), 32'hABCD);
        bus.ReqA = 1'b1;
        wait_ack(ab, rd, er);
        check("t2_lone_a", 32'({ab, rd}), 32'({2'b10, 16'h1234}));
        bus.ReqA = 1'b1; bus.ReqB = 1'b1;
        wait_ack(ab, rd, er);
        check("t2_pair2_first_b", 32'({ab, rd}), 32'({2'b01, 16'hABCD}));
        wait_ack(ab, rd, er);
        check("t2_pair2_second_a", 32'({ab, rd}), 32'({2'b10, 16'h1234}));

        // 3: poller alone
        poll_data = 16'h0004;
        wait_poll(cyc);
        check("t3_poll_seen", 32'(bus.PollDone), 32'd1);
        check("t3_linkup", 32'({bus.LinkUp, bus.Rdat}), 32'({1'b1, 16'h0004}));
        check("t3_poll_cmd", 32'({bus.Fiad, bus.Rgad}), 32'({POLL_FIAD, 5'd1}));
        wait_poll(cyc);
        check("t3_poll_period", 32'(cyc), 32'd100);
        poll_data = 16'h0000;
        wait_poll(cyc);
        check("t3_linkdown", 32'({bus.PollDone, bus.LinkUp, bus.Rdat}), 32'({1'b1, 1'b0, 16'h0000}));

        // 4: request arriving during a poll waits for it
        poll_data = 16'h0004;
        cyc = 0;
        while (!(bus.MiimBusy && bus.Fiad == POLL_FIAD) && cyc < 250) begin
            tick();
            cyc++;
        end
        tick();
        bus.WrB = 1'b1; bus.FiadB = 5'd5; bus.RgadB = 5'd9; bus.WdatB = 16'h00F0;
        bus.ReqB = 1'b1;
        pd_seen = 1'b0;
        cyc = 0;
        while (!bus.AckB && cyc < 300) begin
            if (bus.PollDone) pd_seen = 1'b1;
            tick();
            cyc++;
        end
        check("t4_ackb", 32'({bus.AckB, bus.ErrB, bus.Rdat}), 32'({1'b1, 1'b0, 16'h0000}));
        check("t4_poll_before_b", 32'(pd_seen), 32'd1);
        check("t4_linkup", 32'(bus.LinkUp), 32'd1);
        bus.ReqB = 1'b0;
        tick();

        // 5: MIIM never starts the read -> timeout
        bfm_no_start = 1'b1;
        bus.WrA = 1'b0; bus.FiadA = 5'd4; bus.RgadA = 5'd2;
        bus.ReqA = 1'b1;
        cyc = 0;
        while (!(bus.RStat && bus.Fiad == 5'd4) && cyc < 300) begin
            tick();
            cyc++;
        end
        lat = 0;
        while (!bus.AckA && lat < 200) begin
            tick();
            lat++;
        end
        check("t5_timeout_latency", 32'(lat), 32'd64);
        check("t5_err", 32'({bus.AckA, bus.ErrA, bus.RStat}), 32'b110);
        check("t5_rdat_zero", 32'(bus.Rdat), 32'd0);
        check("t5_linkup_kept", 32'(bus.LinkUp), 32'd1);
        bus.ReqA = 1'b0;
        bfm_no_start = 1'b0;
        tick();
        bus.WrB = 1'b0; bus.FiadB = 5'd3; bus.RgadB = 5'd1;
        bus.ReqB = 1'b1;
        wait_ack(ab, rd, er);
        check("t5_next_ok", 32'({ab, er, rd}), 32'({2'b01, 2'b00, 16'hABCD}));

        // 6: reset during WAIT
        bus.WrA = 1'b1; bus.FiadA = 5'd1; bus.RgadA = 5'd4; bus.WdatA = 16'h1234;
        bus.ReqA = 1'b1;
        cyc = 0;
        while (!(bus.MiimBusy && bus.Fiad == 5'd1) && cyc < 300) begin
            tick();
            cyc++;
        end
        tick();
        Reset_n = 1'b0;
        #1;
        check("t6_async_flags", 32'({bus.AckA, bus.AckB, bus.ErrA, bus.ErrB, bus.LinkUp,
                                     bus.PollDone, bus.WCtrlData, bus.RStat}), 32'd0);
        check("t6_async_cmd", 32'({bus.Fiad, bus.Rgad, bus.CtrlData}), 32'd0);
        bus.ReqA = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        acks = 0;
        repeat (30) begin
            tick();
            if (bus.AckA || bus.AckB) acks++;
        end
        check("t6_no_stray_ack", 32'(acks), 32'd0);
        bus.WrB = 1'b0; bus.FiadB = 5'd2; bus.RgadB = 5'd1;
        bus.ReqB = 1'b1;
        wait_ack(ab, rd, er);
        check("t6_after_reset", 32'({ab, er, rd}), 32'({2'b01, 2'b00, 16'h1234}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
